// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix-multiply block: FSM encoding and
// default array geometry.
package systolic_pkg;

  localparam int N_DEF    = 4;
  localparam int DW_DEF   = 32;
  localparam int KMAX_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/systolic_pe.sv
// One processing element: wrapping multiply-accumulate with synchronous clear,
// plus registered pass-through of A (rightward) and B (downward).
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic signed [DW-1:0] a_in,
  input  logic signed [DW-1:0] b_in,
  output logic signed [DW-1:0] a_out,
  output logic signed [DW-1:0] b_out,
  output logic signed [DW-1:0] acc
);

  // Product and sum both keep only the low DW bits (two's-complement wrap).
  function automatic logic signed [DW-1:0] mac_wrap(
    input logic signed [DW-1:0] s,
    input logic signed [DW-1:0] x,
    input logic signed [DW-1:0] y
  );
    return s + x * y;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (en) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= mac_wrap(acc, a_in, b_in);
    end
  end

endmodule

// File: rtl/systolic_mm.sv
// Output-stationary N x N systolic matrix multiplier: C = A * B with K streamed
// column/row beats, input skew lines, and a feed/flush/done job FSM.
module systolic_mm
  import systolic_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int DW   = DW_DEF,
  parameter int KMAX = KMAX_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [$clog2(KMAX+1)-1:0]   k_len,
  input  logic                        a_valid,
  output logic                        a_ready,
  input  logic [N*DW-1:0]             a_col,
  input  logic [N*DW-1:0]             b_row,
  output logic                        busy,
  output logic                        c_valid,
  input  logic                        c_ready,
  output logic [N*N*DW-1:0]           c_out
);

  localparam int KW = $clog2(KMAX+1);
  localparam int FW = $clog2(2*N);
  localparam logic [KW-1:0] KMAX_K     = KW'(KMAX);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2*N-2);

  state_t          state;
  logic [KW-1:0]   k_reg;
  logic [KW-1:0]   beat_cnt;
  logic [FW-1:0]   flush_cnt;
  logic [KW-1:0]   k_clamp;
  logic            accept;
  logic            adv;
  logic            clr;

  assign k_clamp = (k_len > KMAX_K) ? KMAX_K : k_len;
  assign accept  = (state == S_FEED) && a_valid;
  assign adv     = (state == S_FEED) || (state == S_FLUSH);
  assign clr     = (state == S_IDLE) && start;

  assign a_ready = (state == S_FEED);
  assign busy    = (state != S_IDLE);
  assign c_valid = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      k_reg     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            k_reg     <= k_clamp;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            state     <= (k_clamp == '0) ? S_DONE : S_FEED;
          end
        end
        S_FEED: begin
          if (accept) begin
            beat_cnt <= beat_cnt + KW'(1);
            if (beat_cnt == k_reg - KW'(1)) begin
              flush_cnt <= '0;
              state     <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // 2N-1 cycles drain the last skewed beat through the far corner PE.
          if (flush_cnt == FLUSH_LAST) state <= S_DONE;
          else flush_cnt <= flush_cnt + FW'(1);
        end
        S_DONE: begin
          if (c_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic signed [DW-1:0] a_skew [N];
  logic signed [DW-1:0] b_skew [N];

  genvar i, j;
  for (i = 0; i < N; i++) begin : g_skew
    logic signed [DW-1:0] a_lane;
    logic signed [DW-1:0] b_lane;

    // Cycles without an accepted beat inject zero bubbles.
    assign a_lane = accept ? a_col[i*DW +: DW] : '0;
    assign b_lane = accept ? b_row[i*DW +: DW] : '0;

    if (i == 0) begin : g_direct
      assign a_skew[i] = a_lane;
      assign b_skew[i] = b_lane;
    end else begin : g_delay
      logic signed [DW-1:0] a_sr [i];
      logic signed [DW-1:0] b_sr [i];

      always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
          for (int d = 0; d < i; d++) begin
            a_sr[d] <= '0;
            b_sr[d] <= '0;
          end
        end else if (adv) begin
          a_sr[0] <= a_lane;
          b_sr[0] <= b_lane;
          for (int d = 1; d < i; d++) begin
            a_sr[d] <= a_sr[d-1];
            b_sr[d] <= b_sr[d-1];
          end
        end
      end

      assign a_skew[i] = a_sr[i-1];
      assign b_skew[i] = b_sr[i-1];
    end
  end

  // a_h[i][j] / b_v[i][j] carry PE(i,j) pass-through outputs to its neighbours.
  logic signed [DW-1:0] a_h [N][N-1];
  logic signed [DW-1:0] b_v [N-1][N];
  logic signed [DW-1:0] a_edge_unused [N];
  logic signed [DW-1:0] b_edge_unused [N];

  for (i = 0; i < N; i++) begin : g_row
    for (j = 0; j < N; j++) begin : g_col
      logic signed [DW-1:0] a_i, b_i, a_o, b_o, acc_o;

      if (j == 0) begin : g_a_first
        assign a_i = a_skew[i];
      end else begin : g_a_next
        assign a_i = a_h[i][j-1];
      end

      if (i == 0) begin : g_b_first
        assign b_i = b_skew[j];
      end else begin : g_b_next
        assign b_i = b_v[i-1][j];
      end

      if (j < N-1) begin : g_a_pass
        assign a_h[i][j] = a_o;
      end else begin : g_a_edge
        assign a_edge_unused[i] = a_o;
      end

      if (i < N-1) begin : g_b_pass
        assign b_v[i][j] = b_o;
      end else begin : g_b_edge
        assign b_edge_unused[j] = b_o;
      end

      systolic_pe #(.DW(DW)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .en    (adv),
        .clr   (clr),
        .a_in  (a_i),
        .b_in  (b_i),
        .a_out (a_o),
        .b_out (b_o),
        .acc   (acc_o)
      );

      assign c_out[(i*N+j)*DW +: DW] = acc_o;
    end
  end

endmodule

// File: tb/tb_systolic_mm.sv
// Directed bench for systolic_mm (N=3): scoreboard of reference matrix
// products, latency, bubble, hold, reset and clamp scenarios.
module tb_systolic_mm;

  localparam int N    = 3;
  localparam int DW   = 32;
  localparam int KMAX = 16;
  localparam int KW   = $clog2(KMAX+1);
  localparam int CW   = N*N*DW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic            a_valid = 1'b0;
  logic            a_ready;
  logic [N*DW-1:0] a_col = '0;
  logic [N*DW-1:0] b_row = '0;
  logic            busy;
  logic            c_valid;
  logic            c_ready = 1'b0;
  logic [CW-1:0]   c_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [CW-1:0] sb [$];
  logic [DW-1:0] ma [N][KMAX];
  logic [DW-1:0] mb [KMAX][N];

  systolic_mm #(.N(N), .DW(DW), .KMAX(KMAX)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .k_len   (k_len),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_col   (a_col),
    .b_row   (b_row),
    .busy    (busy),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .c_out   (c_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] model(input int k);
    logic [CW-1:0] r;
    logic [DW-1:0] s;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int t = 0; t < k; t++) s = s + ma[i][t] * mb[t][j];
        r[(i*N+j)*DW +: DW] = s;
      end
    return r;
  endfunction

  task automatic fill_rand();
    for (int t = 0; t < KMAX; t++)
      for (int i = 0; i < N; i++) begin
        ma[i][t] = $urandom;
        mb[t][i] = $urandom;
      end
  endtask

  task automatic fill_zero();
    for (int t = 0; t < KMAX; t++)
      for (int i = 0; i < N; i++) begin
        ma[i][t] = '0;
        mb[t][i] = '0;
      end
  endtask

  task automatic begin_job(input int k);
    start = 1'b1;
    k_len = KW'(k);
    step();
    start = 1'b0;
  endtask

  task automatic feed(input int k, input int gap_at, input int gap_len, output int first);
    first = 0;
    for (int b = 0; b < k; b++) begin
      if (b == gap_at) begin
        a_valid = 1'b0;
        repeat (gap_len) step();
      end
      a_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = ma[i][b];
        b_row[i*DW +: DW] = mb[b][i];
      end
      if (b == 0) first = cyc;
      chk($sformatf("a_ready_beat%0d", b), a_ready, 1);
      step();
    end
    a_valid = 1'b0;
    a_col = '0;
    b_row = '0;
  endtask

  task automatic wait_done(output int at);
    int n;
    n = 0;
    while (!c_valid && n < 200) begin
      step();
      n++;
    end
    at = cyc;
    checks++;
    assert (c_valid === 1'b1) else begin
      failures++;
      $error("FAIL done_timeout observed=%b expected=1", c_valid);
    end
  endtask

  task automatic finish_job(input string tag);
    logic [CW-1:0] exp;
    exp = sb.pop_front();
    chk(tag, c_out, exp);
    c_ready = 1'b1;
    step();
    c_ready = 1'b0;
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int first, at;
    logic [CW-1:0] exp;

    // Reset state
    step();
    step();
    chk("rst_a_ready", a_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_c_valid", c_valid, 0);
    chk("rst_c_out", c_out, 0);
    rst = 1'b0;
    step();

    // Identity A times B = 1..9, a_valid held high
    fill_zero();
    for (int i = 0; i < N; i++) begin
      ma[i][i] = 32'd1;
      for (int j = 0; j < N; j++) mb[i][j] = DW'(i*N + j + 1);
    end
    exp = '0;
    for (int l = 0; l < N*N; l++) exp[l*DW +: DW] = DW'(l + 1);
    begin_job(3);
    chk("busy_feed", busy, 1);
    sb.push_back(exp);
    feed(3, -1, 0, first);
    wait_done(at);
    chk("lat_identity", at - first, 3 + 2*N - 1);
    finish_job("c_identity");

    // Same job with two bubbles between beats 1 and 2
    begin_job(3);
    sb.push_back(exp);
    feed(3, 2, 2, first);
    wait_done(at);
    chk("lat_bubble", at - first, 3 + 2*N - 1 + 2);
    finish_job("c_bubble");

    // Random jobs, with and without bubbles
    for (int r = 0; r < 3; r++) begin
      fill_rand();
      begin_job(5);
      sb.push_back(model(5));
      feed(5, (r == 1) ? 1 : -1, 3, first);
      wait_done(at);
      finish_job($sformatf("c_rand%0d", r));
    end

    // Wrap-around on product
    fill_zero();
    ma[0][0] = 32'h0001_0000;
    mb[0][0] = 32'h0001_0000;
    begin_job(1);
    sb.push_back(model(1));
    feed(1, -1, 0, first);
    wait_done(at);
    chk("wrap_c00", c_out[DW-1:0], 32'h0000_0000);
    finish_job("c_wrap0");

    ma[0][0] = 32'hFFFF_FFFF;
    mb[0][0] = 32'h0000_0002;
    begin_job(1);
    sb.push_back(model(1));
    feed(1, -1, 0, first);
    wait_done(at);
    chk("wrap_c00_neg", c_out[DW-1:0], 32'hFFFF_FFFE);
    finish_job("c_wrap1");

    // DONE hold with c_ready low and start pulses ignored
    fill_rand();
    begin_job(2);
    sb.push_back(model(2));
    feed(2, -1, 0, first);
    wait_done(at);
    exp = sb.pop_front();
    for (int t = 0; t < 10; t++) begin
      start = (t % 2 == 0);
      k_len = KW'(1);
      chk($sformatf("hold_valid%0d", t), c_valid, 1);
      chk($sformatf("hold_cout%0d", t), c_out, exp);
      step();
    end
    c_ready = 1'b1;
    start = 1'b1;
    step();
    c_ready = 1'b0;
    start = 1'b0;
    chk("hold_exit_idle", busy, 0);
    step();
    chk("hold_exit_start_ignored", busy, 0);

    // Reset in the middle of a K=4 job
    fill_rand();
    begin_job(4);
    feed(2, -1, 0, first);
    #2 rst = 1'b1;
    #1;
    chk("midrst_c_out", c_out, 0);
    chk("midrst_a_ready", a_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_c_valid", c_valid, 0);
    step();
    rst = 1'b0;
    step();
    fill_rand();
    begin_job(2);
    sb.push_back(model(2));
    feed(2, -1, 0, first);
    wait_done(at);
    finish_job("c_after_rst");

    // k_len = 0 goes straight to DONE with zero result
    begin_job(0);
    chk("k0_c_valid", c_valid, 1);
    chk("k0_c_out", c_out, 0);
    c_ready = 1'b1;
    step();
    c_ready = 1'b0;
    chk("k0_idle", busy, 0);

    // k_len above KMAX is clamped
    fill_rand();
    begin_job(20);
    sb.push_back(model(KMAX));
    feed(KMAX, -1, 0, first);
    chk("clamp_feed_over", a_ready, 0);
    wait_done(at);
    finish_job("c_clamp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
